vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_sync_edge.sv | 25 ++
 rtl/vga_capture.sv | 163 ++++++++++++++++
 tb/tb_vga_capture.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA capture types and timing constants.
// Holds the capture FSM state encoding and the 10-bit counter/address helpers.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPT
  } state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int         CNT_W   = 10;
  localparam logic [9:0] CNT_MAX = 10'd1023;

  // Counters stick at full scale instead of wrapping back into the window.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Falling-edge detector for an active-low VGA sync line.
// The previous value is only updated on pix_en cycles.
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic sync,
  output logic fall
);

  logic prev;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b1;
    end else if (pix_en) begin
      prev <= sync;
    end
  end

  assign fall = pix_en & prev & ~sync;

endmodule

// File: rtl/vga_capture.sv
// Captures one WIN_W x WIN_H window of a VGA frame into a frame buffer
// through a single-entry write register with mem_ready back-pressure.
module vga_capture
  import vga_pkg::*;
#(
  parameter int WIN_W = 32,
  parameter int WIN_H = 32,
  parameter int X0    = 0,
  parameter int Y0    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank_b,
  input  logic [7:0] vga_pixel,
  input  logic       start,
  input  logic       mem_ready,
  output logic       mem_we,
  output logic [9:0] mem_adr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam logic [10:0] X_LO     = 11'(X0);
  localparam logic [10:0] X_HI     = 11'(X0 + WIN_W);
  localparam logic [10:0] Y_LO     = 11'(Y0);
  localparam logic [10:0] Y_HI     = 11'(Y0 + WIN_H);
  localparam logic [9:0]  X_OFF    = 10'(X0);
  localparam logic [9:0]  Y_OFF    = 10'(Y0);
  localparam logic [9:0]  W_MUL    = 10'(WIN_W);
  localparam logic [9:0]  LAST_ADR = 10'(WIN_W * WIN_H - 1);

  state_t     state, state_nxt;
  logic       hs_fall, vs_fall;
  logic [9:0] col, line;
  logic       line_act;
  logic       active, in_win, accept, last_accept;
  logic       enter_capt, start_acc, early_end, drop;
  logic [9:0] win_adr;

  vga_sync_edge u_hs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .sync   (hsync),
    .fall   (hs_fall)
  );

  vga_sync_edge u_vs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .sync   (vsync),
    .fall   (vs_fall)
  );

  assign active      = pix_en & blank_b;
  assign in_win      = (state == CAPT) && active &&
                       ({1'b0, col} >= X_LO) && ({1'b0, col} < X_HI) &&
                       ({1'b0, line} >= Y_LO) && ({1'b0, line} < Y_HI);
  assign accept      = mem_we & mem_ready;
  assign last_accept = accept && (mem_adr == LAST_ADR);
  assign enter_capt  = (state == ARM) && vs_fall;
  assign early_end   = (state == CAPT) && vs_fall && !last_accept;
  assign drop        = in_win & mem_we & ~mem_ready;
  assign win_adr     = (line - Y_OFF) * W_MUL + (col - X_OFF);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path
  // through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    start_acc  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ARM;
          start_acc = 1'b1;
        end
      end
      ARM: begin
        if (vs_fall) state_nxt = CAPT;
      end
      CAPT: begin
        if (last_accept || vs_fall) begin
          frame_done = 1'b1;
          if (start) begin
            state_nxt = ARM;
            start_acc = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lines only count once they have shown active video, so blanking lines
  // after vsync never shift the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      line     <= '0;
      line_act <= 1'b0;
    end else begin
      if (hs_fall) begin
        col <= '0;
      end else if (active) begin
        col <= sat_inc(col);
      end

      if (enter_capt) begin
        line     <= '0;
        line_act <= 1'b0;
      end else if (hs_fall) begin
        if (line_act) line <= sat_inc(line);
        line_act <= 1'b0;
      end else if (active) begin
        line_act <= 1'b1;
      end
    end
  end

  // A new pixel may replace the entry only when it is empty or leaving now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
    end else if (in_win && (!mem_we || mem_ready)) begin
      mem_we    <= 1'b1;
      mem_adr   <= win_adr;
      mem_wdata <= vga_pixel;
    end else if (accept) begin
      mem_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop || early_end) begin
      overrun <= 1'b1;
    end else if (start_acc) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled-down raster (16x8 active).
// A 4x4 window at the origin and a 4x4 window at col 8 / line 2 share stimulus.
module tb_vga_capture;

  localparam int H_ACT  = 16;
  localparam int HS0    = 18;
  localparam int HS_LEN = 3;
  localparam int H_TOT  = 24;
  localparam int VS_LEN = 2;
  localparam int V_ACT0 = 4;
  localparam int V_ACT  = 8;
  localparam int V_TOT  = 13;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       pix_en = 1'b0, hsync = 1'b1, vsync = 1'b1, blank_b = 1'b0;
  logic [7:0] vga_pixel = 8'd0;
  logic       start = 1'b0, mem_ready = 1'b1;

  logic       mem_we, busy, frame_done, overrun;
  logic [9:0] mem_adr;
  logic [7:0] mem_wdata;
  logic       off_we, off_busy, off_done, off_ovr;
  logic [9:0] off_adr;
  logic [7:0] off_wdata;

  int checks = 0, errors = 0;
  int ready_mode = 0, cyc = 0, cur_v = 0, cur_h = 0;
  int fd_cnt = 0, off_fd_cnt = 0;
  logic [9:0] wr_adr[$], off_adr_q[$], held_adr[$];
  logic [7:0] wr_dat[$], off_dat_q[$], held_dat[$];

  vga_capture #(.WIN_W(4), .WIN_H(4), .X0(0), .Y0(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .blank_b(blank_b), .vga_pixel(vga_pixel), .start(start), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  vga_capture #(.WIN_W(4), .WIN_H(4), .X0(8), .Y0(2)) u_off (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .blank_b(blank_b), .vga_pixel(vga_pixel), .start(start), .mem_ready(mem_ready),
    .mem_we(off_we), .mem_adr(off_adr), .mem_wdata(off_wdata), .busy(off_busy),
    .frame_done(off_done), .overrun(off_ovr)
  );

  always #5 clk = ~clk;

  // Transaction log, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      wr_adr.push_back(mem_adr);
      wr_dat.push_back(mem_wdata);
    end
    if (mem_we && !mem_ready) begin
      held_adr.push_back(mem_adr);
      held_dat.push_back(mem_wdata);
    end
    if (frame_done) fd_cnt++;
    if (off_we && mem_ready) begin
      off_adr_q.push_back(off_adr);
      off_dat_q.push_back(off_wdata);
    end
    if (off_done) off_fd_cnt++;
  end

  task automatic clear_log();
    wr_adr.delete(); wr_dat.delete(); held_adr.delete(); held_dat.delete();
    off_adr_q.delete(); off_dat_q.delete();
    fd_cnt = 0; off_fd_cnt = 0;
  endtask

  task automatic set_ready();
    cyc++;
    case (ready_mode)
      1:       mem_ready = cyc[0];
      2:       mem_ready = !(cur_v == V_ACT0 + 1 && cur_h >= 1 && cur_h <= 3);
      default: mem_ready = 1'b1;
    endcase
  endtask

  task automatic pix_period(input logic hs, input logic vs, input logic bl,
                            input logic [7:0] px);
    hsync = hs; vsync = vs; blank_b = bl; vga_pixel = px;
    pix_en = 1'b1; set_ready();
    @(posedge clk); #1;
    pix_en = 1'b0; set_ready();
    @(posedge clk); #1;
  endtask

  task automatic raster_frame();
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        cur_v = v; cur_h = h;
        pix_period((h >= HS0 && h < HS0 + HS_LEN) ? 1'b0 : 1'b1,
                   (v < VS_LEN) ? 1'b0 : 1'b1,
                   (v >= V_ACT0 && v < V_ACT0 + V_ACT && h < H_ACT),
                   (v >= V_ACT0 && v < V_ACT0 + V_ACT && h < H_ACT) ?
                     8'(h + v - V_ACT0) : 8'd0);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (mem_we !== 1'b0 || mem_adr !== 10'd0 || mem_wdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b adr=%0d data=%0d, expected 0/0/0", mem_we, mem_adr, mem_wdata);
    end
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b ovr=%b, expected 0/0/0", busy, frame_done, overrun);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_full_frame();
    clear_log();
    ready_mode = 0;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL full_arm: got busy=%b, expected 1", busy);
    end
    raster_frame();
    checks++;
    if (wr_adr.size() != 16) begin
      errors++;
      $display("FAIL full_count: got %0d writes, expected 16", wr_adr.size());
    end
    for (int i = 0; i < wr_adr.size() && i < 16; i++) begin
      checks++;
      if (wr_adr[i] !== 10'(i) || wr_dat[i] !== 8'(i % 4 + i / 4)) begin
        errors++;
        $display("FAIL full_write[%0d]: got adr %0d data %0d, expected adr %0d data %0d",
                 i, wr_adr[i], wr_dat[i], i, i % 4 + i / 4);
      end
    end
    checks++;
    if (fd_cnt != 1 || overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_end: got done=%0d ovr=%b busy=%b, expected 1/0/0", fd_cnt, overrun, busy);
    end
  endtask

  task automatic test_stall();
    logic [9:0] exp_adr[$];
    for (int i = 0; i < 16; i++) if (i != 6 && i != 7) exp_adr.push_back(10'(i));
    clear_log();
    ready_mode = 2;
    pulse_start();
    raster_frame();
    ready_mode = 0;
    checks++;
    if (wr_adr.size() != 14) begin
      errors++;
      $display("FAIL stall_count: got %0d writes, expected 14", wr_adr.size());
    end
    for (int i = 0; i < wr_adr.size() && i < 14; i++) begin
      checks++;
      if (wr_adr[i] !== exp_adr[i] || wr_dat[i] !== 8'(exp_adr[i] % 4 + exp_adr[i] / 4)) begin
        errors++;
        $display("FAIL stall_write[%0d]: got adr %0d data %0d, expected adr %0d data %0d",
                 i, wr_adr[i], wr_dat[i], exp_adr[i], exp_adr[i] % 4 + exp_adr[i] / 4);
      end
    end
    checks++;
    if (held_adr.size() != 5) begin
      errors++;
      $display("FAIL stall_held_cycles: got %0d, expected 5", held_adr.size());
    end
    for (int i = 0; i < held_adr.size(); i++) begin
      checks++;
      if (held_adr[i] !== 10'd5 || held_dat[i] !== 8'd2) begin
        errors++;
        $display("FAIL stall_held[%0d]: got adr %0d data %0d, expected adr 5 data 2",
                 i, held_adr[i], held_dat[i]);
      end
    end
    idle(10);
    checks++;
    if (overrun !== 1'b1 || fd_cnt != 1) begin
      errors++;
      $display("FAIL stall_overrun: got ovr=%b done=%0d, expected 1/1", overrun, fd_cnt);
    end
    pulse_start();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear: got ovr=%b after start, expected 0", overrun);
    end
    clear_log();
    raster_frame();
    checks++;
    if (wr_adr.size() != 16 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL stall_recover: got %0d writes ovr=%b, expected 16/0", wr_adr.size(), overrun);
    end
  endtask

  task automatic test_toggle();
    clear_log();
    ready_mode = 1;
    pulse_start();
    raster_frame();
    ready_mode = 0;
    mem_ready  = 1'b1;
    checks++;
    if (wr_adr.size() != 16) begin
      errors++;
      $display("FAIL toggle_count: got %0d writes, expected 16", wr_adr.size());
    end
    for (int i = 0; i < wr_adr.size() && i < 16; i++) begin
      checks++;
      if (wr_adr[i] !== 10'(i) || wr_dat[i] !== 8'(i % 4 + i / 4)) begin
        errors++;
        $display("FAIL toggle_write[%0d]: got adr %0d data %0d, expected adr %0d data %0d",
                 i, wr_adr[i], wr_dat[i], i, i % 4 + i / 4);
      end
    end
    checks++;
    if (overrun !== 1'b0 || fd_cnt != 1) begin
      errors++;
      $display("FAIL toggle_end: got ovr=%b done=%0d, expected 0/1", overrun, fd_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n_after;
    seen = 1'b0;
    n_after = 0;
    clear_log();
    pulse_start();
    fork
      raster_frame();
      begin
        for (int i = 0; i < 800 && !seen; i++) begin
          @(negedge clk);
          if (mem_we && mem_adr == 10'd4) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL rstmid_trigger: 5th write never presented, expected within 800 cycles");
        end else begin
          #2 rst_n = 1'b0;
          #1;
          checks++;
          if (mem_we !== 1'b0 || mem_adr !== 10'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got we=%b adr=%0d busy=%b, expected 0/0/0", mem_we, mem_adr, busy);
          end
          @(posedge clk); @(posedge clk); #1;
          rst_n = 1'b1;
          n_after = wr_adr.size();
        end
      end
    join
    checks++;
    if (wr_adr.size() != n_after || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d writes after release busy=%b, expected 0/0",
               wr_adr.size() - n_after, busy);
    end
    clear_log();
    pulse_start();
    raster_frame();
    checks++;
    if (wr_adr.size() != 16 || fd_cnt != 1) begin
      errors++;
      $display("FAIL rstmid_recap: got %0d writes done=%0d, expected 16/1", wr_adr.size(), fd_cnt);
    end
    for (int i = 0; i < wr_adr.size() && i < 16; i++) begin
      checks++;
      if (wr_adr[i] !== 10'(i) || wr_dat[i] !== 8'(i % 4 + i / 4)) begin
        errors++;
        $display("FAIL rstmid_write[%0d]: got adr %0d data %0d, expected adr %0d data %0d",
                 i, wr_adr[i], wr_dat[i], i, i % 4 + i / 4);
      end
    end
  endtask

  task automatic test_offset_window();
    clear_log();
    pulse_start();
    raster_frame();
    checks++;
    if (off_adr_q.size() != 16 || off_fd_cnt != 1) begin
      errors++;
      $display("FAIL offset_count: got %0d writes done=%0d, expected 16/1", off_adr_q.size(), off_fd_cnt);
    end
    for (int i = 0; i < off_adr_q.size() && i < 16; i++) begin
      checks++;
      if (off_adr_q[i] !== 10'(i) || off_dat_q[i] !== 8'(8 + i % 4 + 2 + i / 4)) begin
        errors++;
        $display("FAIL offset_write[%0d]: got adr %0d data %0d, expected adr %0d data %0d",
                 i, off_adr_q[i], off_dat_q[i], i, 10 + i % 4 + i / 4);
      end
    end
    checks++;
    if (off_ovr !== 1'b0 || off_busy !== 1'b0) begin
      errors++;
      $display("FAIL offset_end: got ovr=%b busy=%b, expected 0/0", off_ovr, off_busy);
    end
  endtask

  task automatic test_start_rules();
    bit seen;
    // start during CAPT must not re-arm
    clear_log();
    pulse_start();
    fork
      raster_frame();
      begin
        for (int i = 0; i < 800 && wr_adr.size() < 3; i++) @(negedge clk);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    checks++;
    if (wr_adr.size() != 16 || fd_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: got %0d writes done=%0d busy=%b, expected 16/1/0",
               wr_adr.size(), fd_cnt, busy);
    end
    // start in the frame_done cycle must re-arm
    seen = 1'b0;
    clear_log();
    pulse_start();
    fork
      raster_frame();
      begin
        for (int i = 0; i < 800 && !seen; i++) begin
          @(negedge clk);
          if (frame_done) seen = 1'b1;
        end
        checks++;
        if (!seen || mem_adr !== 10'd15) begin
          errors++;
          $display("FAIL done_cycle: got seen=%b adr=%0d, expected 1/15", seen, mem_adr);
        end
        if (seen) begin
          start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rearm_busy: got busy=%b, expected 1", busy);
          end
        end
      end
    join
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rearm_hold: got busy=%b at frame end, expected 1", busy);
    end
    clear_log();
    raster_frame();
    checks++;
    if (wr_adr.size() != 16 || fd_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rearm_capture: got %0d writes done=%0d busy=%b, expected 16/1/0",
               wr_adr.size(), fd_cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_toggle();
    test_reset_mid();
    test_offset_window();
    test_start_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
